fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 116 +++++++++++
 tb/tb_fetch_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and ROM fetch front end feeding decode
// through a DEPTH-entry PC-tagged instruction queue with redirect flush.
module fetch_queue #(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 15,
  parameter int DEPTH   = 4,
  parameter logic [PC_W-1:0] RESET_PC = 'o4000
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       rom_req,
  output logic [PC_W-1:0]            rom_addr,
  input  logic [INSTR_W-1:0]         rom_data,
  input  logic                       redirect_en,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic                       hold,
  output logic                       out_valid,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]            out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic [INSTR_W-1:0] mem_instr_q [DEPTH];
  logic [INSTR_W-1:0] mem_instr_d [DEPTH];
  logic [PC_W-1:0]    mem_pc_q [DEPTH];
  logic [PC_W-1:0]    mem_pc_d [DEPTH];

  logic               pop;
  logic               push;
  logic [CW:0]        occ;

  // Head presentation and the slot-reserving issue rule.
  always_comb begin
    out_valid = (count_q != '0);
    out_instr = out_valid ? mem_instr_q[head_q] : '0;
    out_pc    = out_valid ? mem_pc_q[head_q] : '0;
    pop       = out_valid & out_ready;
    push      = inflight_q;
    occ       = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    rom_req   = ~reset & ~redirect_en & ~hold
              & (occ < (CW+1)'(DEPTH));
    rom_addr  = fetch_pc_q;
    count     = count_q;
  end

  // Next state: redirect flushes everything, else push/pop/issue.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    mem_instr_d   = mem_instr_q;
    mem_pc_d      = mem_pc_q;
    if (redirect_en) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        mem_instr_d[tail_q] = rom_data;
        mem_pc_d[tail_q]    = inflight_pc_q;
        tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
      end
      if (pop) begin
        head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
      end
      count_d    = count_q + CW'(push) - CW'(pop);
      inflight_d = rom_req;
      if (rom_req) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 1'b1;
      end
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // Queue storage; contents are only meaningful below count_q.
  always_ff @(posedge clock) begin
    mem_instr_q <= mem_instr_d;
    mem_pc_q    <= mem_pc_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench for fetch_queue
// against a queue-based model of the fetch/deliver contract.
module tb_fetch_queue;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 15;
  localparam int DEPTH   = 4;
  localparam int CW      = $clog2(DEPTH+1);
  localparam logic [PC_W-1:0] RST_PC = 12'o4000;
  localparam int NCYC    = 3000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ent_t;

  logic               clock = 1'b0;
  logic               reset;
  logic               rom_req;
  logic [PC_W-1:0]    rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               redirect_en;
  logic [PC_W-1:0]    redirect_pc;
  logic               hold;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               out_ready;
  logic [CW-1:0]      count;

  int checks = 0;
  int errors = 0;
  bit live   = 0;

  ent_t            exp_q[$];
  logic [PC_W-1:0] m_pc;
  bit              m_infl;
  logic [PC_W-1:0] m_ipc;

  fetch_queue #(
    .PC_W(PC_W), .INSTR_W(INSTR_W),
    .DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .clock(clock), .reset(reset),
    .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_data(rom_data),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .hold(hold),
    .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_ready(out_ready),
    .count(count)
  );

  always #5 clock = ~clock;

  function automatic logic [INSTR_W-1:0] rom_fn(
    input logic [PC_W-1:0] a);
    return {a[2:0] ^ 3'b101, a};
  endfunction

  // Synchronous ROM: data one cycle after the strobe, junk otherwise.
  always @(posedge clock)
    rom_data <= rom_req ? rom_fn(rom_addr)
                        : INSTR_W'($urandom);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: compare the head against the scoreboard, pop on accept.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (live) begin
        chk("count", 32'(count), 32'(exp_q.size()));
        chk("out_valid", 32'(out_valid),
            32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          chk("out_pc", 32'(out_pc), 32'(exp_q[0].pc));
          chk("out_instr", 32'(out_instr),
              32'(exp_q[0].instr));
          if (out_ready) void'(exp_q.pop_front());
        end else begin
          chk("out_pc_zero", 32'(out_pc), 0);
          chk("out_instr_zero", 32'(out_instr), 0);
        end
      end
    end
  end

  task automatic drive(input int c);
    reset       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    hold        = 1'b0;
    out_ready   = 1'b1;
    if (c == 0 || c == 13 || c == 80) reset = 1'b1;
    else if (c >= 14 && c <= 25) out_ready = 1'b0;
    else if (c == 36) begin
      redirect_en = 1'b1;
      redirect_pc = 12'o2000;
    end else if (c == 45) begin
      redirect_en = 1'b1;
      redirect_pc = 12'o7776;
    end else if (c >= 56 && c <= 57) out_ready = 1'b0;
    else if (c >= 58 && c <= 65) hold = 1'b1;
    else if (c >= 76 && c <= 79) out_ready = 1'b0;
    else if (c > 80) begin
      reset       = ($urandom_range(0, 99) < 1);
      redirect_en = ($urandom_range(0, 99) < 6);
      redirect_pc = $urandom_range(0, 1) ?
                    PC_W'(12'o7774 + $urandom_range(0, 3)) :
                    PC_W'($urandom);
      hold        = ($urandom_range(0, 99) < 20);
      out_ready   = ($urandom_range(0, 99) < 60);
    end
  endtask

  // Stimulus and model step: issue rule, then edge effects.
  initial begin
    bit exp_req;
    reset = 1'b1; redirect_en = 1'b0; redirect_pc = '0;
    hold = 1'b0; out_ready = 1'b0;
    @(posedge clock);
    m_pc = RST_PC; m_infl = 0; m_ipc = '0;
    exp_q.delete();
    live = 1;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clock);
      drive(c);
      #2;
      exp_req = !reset && !redirect_en && !hold &&
                (exp_q.size() + int'(m_infl) < DEPTH);
      chk("rom_req", 32'(rom_req), 32'(exp_req));
      chk("rom_addr", 32'(rom_addr), 32'(m_pc));
      if (reset) begin
        exp_q.delete();
        m_infl = 0;
        m_pc   = RST_PC;
      end else if (redirect_en) begin
        exp_q.delete();
        m_infl = 0;
        m_pc   = redirect_pc;
      end else begin
        if (m_infl) exp_q.push_back('{m_ipc, rom_fn(m_ipc)});
        m_infl = exp_req;
        if (exp_req) begin
          m_ipc = m_pc;
          m_pc  = m_pc + 1'b1;
        end
      end
    end
    @(negedge clock);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
